// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tetris_pkg
//  Purpose  : Types and sizes shared by the board stage and the LED matrix
//             scanner (board geometry, frame type, scanner state encoding).
//  Revision : 1.0  initial release
// ============================================================================
package tetris_pkg;

  localparam int BOARD_ROWS = 15;
  localparam int BOARD_COLS = 8;

  // One full board frame; index 0 is the top row, bit COLS-1 the leftmost column
  typedef logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] board_t;

  // Scanner sequencing: idle -> snapshot -> (drive -> blank) per row
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRIVE = 2'd2,
    S_BLANK = 2'd3
  } scan_state_t;

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Loadable down-counter that saturates at zero; done flags zero.
//             Shared by the row dwell and row blanking intervals.
//  Revision : 1.0  initial release
// ============================================================================
module scan_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; otherwise count down and hold at zero (never wraps)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign done = (r_count == '0);

endmodule : scan_timer
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scanner
//  Purpose  : Snapshots the board once per frame and time-multiplexes it onto
//             the LED matrix one row at a time with dark gaps between rows.
//  Revision : 1.0  initial release
// ============================================================================
module led_matrix_scanner
  import tetris_pkg::*;
#(
  parameter int ROWS  = BOARD_ROWS,
  parameter int COLS  = BOARD_COLS,
  parameter int DWELL = 2048,
  parameter int BLANK = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ROWS-1:0][COLS-1:0]  board_in,
  input  logic                       enable,
  output logic [ROWS-1:0]            row_sel,
  output logic [COLS-1:0]            col_data,
  output logic [3:0]                 scan_row,
  output logic                       frame_start
);

  localparam int             c_timer_w  = $clog2(((DWELL > BLANK) ? DWELL : BLANK) + 1);
  localparam logic [c_timer_w-1:0] c_dwell_ld = c_timer_w'(DWELL - 1);
  localparam logic [c_timer_w-1:0] c_blank_ld = c_timer_w'(BLANK - 1);
  localparam logic [3:0]     c_last_row = 4'(ROWS - 1);

  if (DWELL < 1) begin : g_bad_dwell
    $error("led_matrix_scanner: DWELL must be >= 1");
  end
  if (BLANK < 1) begin : g_bad_blank
    $error("led_matrix_scanner: BLANK must be >= 1");
  end
  if (ROWS > 16) begin : g_bad_rows
    $error("led_matrix_scanner: ROWS must fit the 4-bit scan_row");
  end

  scan_state_t                 r_state;
  scan_state_t                 w_next_state;
  logic [ROWS-1:0][COLS-1:0]   r_frame_buf;
  logic [ROWS-1:0]             r_row_sel;
  logic [COLS-1:0]             r_col_data;
  logic [3:0]                  r_scan_row;
  logic                        r_frame_start;
  logic [3:0]                  w_next_row;
  logic [ROWS-1:0]             w_row_sel;
  logic [COLS-1:0]             w_col_data;
  logic [COLS-1:0]             w_row_bits;
  logic                        w_timer_load;
  logic [c_timer_w-1:0]        w_timer_val;
  logic                        w_timer_en;
  logic                        w_timer_done;

  scan_timer #(
    .WIDTH (c_timer_w)
  ) u_scan_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_timer_load),
    .load_val (w_timer_val),
    .en       (w_timer_en),
    .done     (w_timer_done)
  );

  // Next state, next row and the output values that the next state will show
  always_comb begin
    w_next_state = r_state;
    w_next_row   = r_scan_row;
    w_timer_val  = '0;
    w_row_sel    = '0;
    w_col_data   = '0;

    case (r_state)
      S_IDLE:  if (enable) w_next_state = S_LOAD;
      S_LOAD: begin
        w_next_state = S_DRIVE;
        w_next_row   = '0;
      end
      S_DRIVE: if (w_timer_done) w_next_state = S_BLANK;
      S_BLANK: begin
        if (w_timer_done) begin
          if (r_scan_row == c_last_row) begin
            w_next_row   = '0;
            w_next_state = S_LOAD;
          end else begin
            w_next_row   = r_scan_row + 4'd1;
            w_next_state = S_DRIVE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    // Disabling always parks the scanner dark at row 0; re-enable restarts the frame
    if (!enable) begin
      w_next_state = S_IDLE;
      w_next_row   = '0;
    end

    // Every state entry reloads the timer; idle/load park it at zero
    w_timer_load = (w_next_state != r_state) || !enable;
    if (w_next_state == S_DRIVE) begin
      w_timer_val = c_dwell_ld;
    end else if (w_next_state == S_BLANK) begin
      w_timer_val = c_blank_ld;
    end

    // Row 0 is driven on the same edge the snapshot is captured, so bypass the buffer
    w_row_bits = (r_state == S_LOAD) ? board_in[w_next_row] : r_frame_buf[w_next_row];
    if (w_next_state == S_DRIVE) begin
      w_row_sel[w_next_row] = 1'b1;
      w_col_data            = w_row_bits;
    end
  end

  assign w_timer_en = (r_state == S_DRIVE) || (r_state == S_BLANK);

  // Registered state, snapshot and matrix outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_frame_buf   <= '0;
      r_row_sel     <= '0;
      r_col_data    <= '0;
      r_scan_row    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_row_sel     <= w_row_sel;
      r_col_data    <= w_col_data;
      r_scan_row    <= w_next_row;
      r_frame_start <= (w_next_state == S_LOAD);
      if ((r_state == S_LOAD) && enable) begin
        r_frame_buf <= board_in;
      end
    end
  end

  assign row_sel     = r_row_sel;
  assign col_data    = r_col_data;
  assign scan_row    = r_scan_row;
  assign frame_start = r_frame_start;

endmodule : led_matrix_scanner
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_matrix_scanner
//  Purpose  : Self-checking bench for led_matrix_scanner with DWELL=4, BLANK=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_matrix_scanner;

  localparam int ROWS = 15;
  localparam int COLS = 8;
  localparam int DW   = 4;
  localparam int BL   = 2;
  localparam int PER  = 1 + ROWS * (DW + BL);

  logic                      clk = 1'b0;
  logic                      reset;
  logic [ROWS-1:0][COLS-1:0] board_in;
  logic                      enable;
  logic [ROWS-1:0]           row_sel;
  logic [COLS-1:0]           col_data;
  logic [3:0]                scan_row;
  logic                      frame_start;

  led_matrix_scanner #(
    .ROWS (ROWS), .COLS (COLS), .DWELL (DW), .BLANK (BL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .board_in    (board_in),
    .enable      (enable),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .scan_row    (scan_row),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: position within the frame counted from the snapshot cycle
  bit                        m_active = 0;
  int                        m_pos    = 0;
  logic [ROWS-1:0][COLS-1:0] m_snap   = '0;

  logic [ROWS-1:0] prev_sel = '0;
  int              run      = 0;

  typedef struct {
    logic            en;
    logic [ROWS-1:0] rs;
    logic [COLS-1:0] cd;
    logic [3:0]      sr;
    logic            fs;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!reset || !enable) begin
      m_active = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_pos    = 0;
    end else begin
      m_pos = (m_pos + 1) % PER;
      if (m_pos == 1) m_snap = board_in;
    end
  endtask

  function automatic logic [27:0] model_exp();
    logic [ROWS-1:0] rs;
    logic [COLS-1:0] cd;
    logic [3:0]      sr;
    logic            fs;
    int k, row, w;
    rs = '0; cd = '0; sr = '0; fs = 1'b0;
    if (m_active) begin
      if (m_pos == 0) begin
        fs = 1'b1;
      end else begin
        k   = m_pos - 1;
        row = k / (DW + BL);
        w   = k % (DW + BL);
        sr  = 4'(row);
        if (w < DW) begin
          rs = ROWS'(1) << row;
          cd = m_snap[row];
        end
      end
    end
    return {rs, cd, sr, fs};
  endfunction

  task automatic check_invariants();
    checks++;
    if ($countones(row_sel) > 1 || (row_sel == '0 && col_data != '0)) begin
      errors++;
      $display("FAIL invariant: row_sel=%h col_data=%h (t=%0t)", row_sel, col_data, $time);
    end
    if (row_sel != '0 && row_sel == prev_sel) run++;
    else if (row_sel != '0) run = 1;
    else run = 0;
    prev_sel = row_sel;
    checks++;
    if (run > DW) begin
      errors++;
      $display("FAIL dwell_len: row_sel=%h lit %0d cycles, max %0d", row_sel, run, DW);
    end
  endtask

  task automatic tick(input bit cmp);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (cmp) chk("model", {4'b0, row_sel, col_data, scan_row, frame_start}, {4'b0, model_exp()});
    check_invariants();
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    tick(1);
    tick(1);
    reset  = 1'b1;
  endtask

  task automatic wait_sel(input logic [ROWS-1:0] sel, input string nm);
    int n = 0;
    while (row_sel !== sel && n < 300) begin
      tick(1);
      n++;
    end
    if (row_sel !== sel) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, row_sel=%h expected %h", nm, row_sel, sel);
    end
  endtask

  task automatic wait_fs(input string nm);
    int n = 0;
    while (frame_start !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    if (frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, frame_start=%b expected 1", nm, frame_start);
    end
  endtask

  task automatic apply_table(input string tag);
    board_in    = '0;
    board_in[0] = 8'b0001_1000;
    for (int i = 0; i < 8; i++) begin
      enable = tv[i].en;
      tick(0);
      chk({tag, "_row_sel"},  32'(row_sel),     32'(tv[i].rs));
      chk({tag, "_col_data"}, 32'(col_data),    32'(tv[i].cd));
      chk({tag, "_scan_row"}, 32'(scan_row),    32'(tv[i].sr));
      chk({tag, "_fstart"},   32'(frame_start), 32'(tv[i].fs));
    end
  endtask

  initial begin
    int fs_first;
    int fs_second;

    tv[0] = '{1'b1, 15'h0000, 8'h00, 4'd0, 1'b1};
    tv[1] = '{1'b1, 15'h0001, 8'h18, 4'd0, 1'b0};
    tv[2] = '{1'b1, 15'h0001, 8'h18, 4'd0, 1'b0};
    tv[3] = '{1'b1, 15'h0001, 8'h18, 4'd0, 1'b0};
    tv[4] = '{1'b1, 15'h0001, 8'h18, 4'd0, 1'b0};
    tv[5] = '{1'b1, 15'h0000, 8'h00, 4'd0, 1'b0};
    tv[6] = '{1'b1, 15'h0000, 8'h00, 4'd0, 1'b0};
    tv[7] = '{1'b1, 15'h0002, 8'h00, 4'd1, 1'b0};

    reset    = 1'b0;
    enable   = 1'b0;
    board_in = '0;

    // Reset state
    tick(1);
    chk("reset_row_sel",  32'(row_sel),     32'h0);
    chk("reset_col_data", 32'(col_data),    32'h0);
    chk("reset_scan_row", 32'(scan_row),    32'h0);
    chk("reset_fstart",   32'(frame_start), 32'h0);
    reset = 1'b1;

    // Scenario 1: first frame timing
    apply_table("s1");

    // Scenario 2: full frames with board[r] = r+1, frame period
    do_reset();
    for (int r = 0; r < ROWS; r++) board_in[r] = 8'(r + 1);
    enable    = 1'b1;
    fs_first  = -1;
    fs_second = -1;
    for (int i = 0; i < 2 * PER + 10; i++) begin
      tick(1);
      if (frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = cyc;
        else if (fs_second < 0) fs_second = cyc;
      end
    end
    chk("s2_frame_period", 32'(fs_second - fs_first), 32'd91);

    // Scenario 3: mid-frame board change appears only in the next frame
    do_reset();
    board_in = '0;
    enable   = 1'b1;
    wait_sel(15'h0002, "s3_wait_row1");
    board_in[3] = 8'hFF;
    wait_sel(15'h0008, "s3_wait_row3_a");
    chk("s3_row3_cur_frame", 32'(col_data), 32'h00);
    wait_fs("s3_wait_fs");
    wait_sel(15'h0008, "s3_wait_row3_b");
    chk("s3_row3_next_frame", 32'(col_data), 32'hFF);

    // Scenario 4: one-cycle enable drop during row 7 restarts the frame
    do_reset();
    for (int r = 0; r < ROWS; r++) board_in[r] = 8'(r + 1);
    enable = 1'b1;
    wait_sel(15'h0080, "s4_wait_row7");
    tick(1);
    enable = 1'b0;
    tick(1);
    chk("s4_dark_row_sel",  32'(row_sel),  32'h0);
    chk("s4_dark_col_data", 32'(col_data), 32'h0);
    chk("s4_dark_scan_row", 32'(scan_row), 32'h0);
    enable = 1'b1;
    tick(1);
    chk("s4_restart_fstart", 32'(frame_start), 32'h1);
    tick(1);
    chk("s4_restart_row0", 32'(row_sel), 32'h0001);
    chk("s4_restart_col0", 32'(col_data), 32'h01);

    // Scenario 5: asynchronous reset mid-drive, then the first-frame sequence again
    do_reset();
    apply_table("s5a");
    reset = 1'b0;
    #1;
    chk("s5_async_row_sel",  32'(row_sel),  32'h0);
    chk("s5_async_col_data", 32'(col_data), 32'h0);
    m_active = 0;
    tick(1);
    tick(1);
    reset = 1'b1;
    apply_table("s5b");

    // Scenario 6: random board and enable toggles against the model
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      for (int r = 0; r < ROWS; r++) board_in[r] = 8'($urandom);
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_led_matrix_scanner
`default_nettype wire

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Downstream display stage of the game board. It consumes the 15x8 `current_board` frame and time-multiplexes it onto the LED matrix one row at a time, using a one-hot row driver and 8 column lines. The board is snapshotted once per frame, so mid-frame board updates never tear the image. Configurable blanking between rows suppresses ghosting.

Parameters:
ROWS, 15, number of board rows scanned (matches current_board depth)
COLS, 8, column lines per row (matches current_board width)
DWELL, 2048, clk cycles each row is lit; must be >= 1 (elaboration-time check)
BLANK, 16, clk cycles all rows are dark between rows; must be >= 1 (elaboration-time check)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
board_in  input  [ROWS-1:0][COLS-1:0]  frame from the board stage; index 0 = top row, bit COLS-1 = leftmost column
enable  input  1  scan enable; when low the display is dark
row_sel  output  ROWS  one-hot row drive, active-high
col_data  output  COLS  column drive for the active row, active-high
scan_row  output  4  index of the row being driven or blanked
frame_start  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- All outputs are registered.
- While reset=0, the block asynchronously sets: row_sel=0, col_data=0, scan_row=0, frame_start=0, frame buffer=0, state=S_IDLE, timer=0.
- States:
  - S_IDLE: outputs dark. If enable=1, go to S_LOAD.
  - S_LOAD: exactly 1 cycle. frame_buf <= board_in; frame_start=1 for this cycle only; scan_row=0; then go to S_DRIVE.
  - S_DRIVE: row_sel = 1<<scan_row; col_data = frame_buf[scan_row]. Held for exactly DWELL cycles, then go to S_BLANK.
  - S_BLANK: row_sel=0, col_data=0 for exactly BLANK cycles. Then:
    - if scan_row == ROWS-1: scan_row <= 0 and go to S_LOAD;
    - else: scan_row <= scan_row+1 and go to S_DRIVE.
- Frame period = 1 + ROWS*(DWELL+BLANK) cycles. With the defaults this is 30961 cycles.
- Latency: on the first clk edge with reset=1 and enable=1, the block enters S_LOAD. Row 0 is visible on the following edge.
- The snapshot is taken only in S_LOAD. Changes to board_in during S_DRIVE or S_BLANK are invisible until the next frame.
- enable=0 in any state: on the next edge, force row_sel=0, col_data=0, scan_row=0, timer=0, state=S_IDLE. frame_buf is retained. On re-enable the scan always restarts with S_LOAD, never mid-frame.
- Invariant: row_sel is either zero or one-hot at every cycle. It is never multi-hot, including across S_DRIVE<->S_BLANK transitions and enable toggles.
- Invariant: col_data=0 whenever row_sel=0.
- Timer: down-counter of width $clog2(max(DWELL,BLANK)+1). It is loaded with DWELL-1 or BLANK-1 on state entry, and the state ends when the timer reaches 0 (no off-by-one allowed). The timer does not wrap.
- Asserting reset mid-row darkens the outputs immediately (asynchronously), not at the next edge.

Decomposition:
- Shared package tetris_pkg holds:
  - BOARD_ROWS=15 and BOARD_COLS=8;
  - typedef board_t = logic [BOARD_ROWS-1:0][BOARD_COLS-1:0], shared with the board stage;
  - enum scan_state_t {S_IDLE, S_LOAD, S_DRIVE, S_BLANK}.
- One sub-module: scan_timer, a loadable down-counter.
  - Inputs: clk, reset, load, load_val, en.
  - Output: done, high when count==0.
  - Instantiated once and reused for both the dwell and blank intervals.

Test Plan:
All scenarios use DWELL=4, BLANK=2, frame period 91 cycles.
1. Reset release, enable=1, board_in[0]=8'b00011000, all other rows 0.
   -> frame_start pulses on edge 1.
   -> row_sel=15'h0001 and col_data=8'h18 for edges 2-5.
   -> outputs dark for edges 6-7.
   -> row_sel=15'h0002 with col_data=0 on edge 8.
2. Full frame with board_in[r]=r+1.
   -> Each row r is lit for exactly 4 cycles with col_data=r+1, in row order 0..14.
   -> The next frame_start pulse arrives 91 cycles after the previous one.
3. Change board_in[3] from 8'h00 to 8'hFF while row 1 is being driven.
   -> Row 3 shows 8'h00 in the current frame and 8'hFF in the next frame.
4. Drop enable for 1 cycle during row 7's S_DRIVE.
   -> Outputs are 0 on the next edge.
   -> After re-enable, frame_start pulses and row 0 follows; row 8 is never driven before row 0.
5. Assert reset (drive it to 0) mid-S_DRIVE between clock edges.
   -> row_sel=0 and col_data=0 immediately.
   -> After release, the same sequence as scenario 1 is observed.
6. Random board_in with random enable toggles for 10k cycles.
   -> A checker confirms row_sel is always zero or one-hot, col_data=0 whenever row_sel=0, and no row is lit longer than DWELL cycles.
